// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//   Instruction fetch front end. Issues in-order word reads to memory, tags
//   each in-flight read with its PC, buffers returned words in a small FIFO
//   and presents them to the decoder. A redirect (iFlushPipe) reloads the PC,
//   empties the buffers and discards responses still owed by memory
//   (S_DROP state).
//
// Handshakes:
//   Memory request: oMemReq is the valid, iMemGnt the ready; a transfer
//   happens on a rising edge where both are high. While oMemReq is high and
//   not granted, oMemReq/oMemAddr hold, unless a redirect arrives.
//   Memory response: iMemRvalid has no back-pressure; responses come back in
//   request order. Decoder: oInstDv is the valid, !iStall the ready; a word
//   is consumed on a rising edge where oInstDv is high and iStall is low.
//
// Ports:
//   iClk, iRst        clock, synchronous active-high reset
//   oMemReq/oMemAddr  read request valid / byte address (4-aligned)
//   iMemGnt           memory accepts the request this cycle
//   iMemRvalid/Rdata  read response valid / instruction word
//   oInst/oCurPc      instruction and its PC for the decoder
//   oInstDv           oInst/oCurPc valid
//   iStall            decoder cannot accept
//   iFlushPipe/PC     redirect request / target (bits [1:0] ignored)
//   oProtoErr         sticky: a response arrived with nothing outstanding
//   oDbgState         FSM state (0 = S_RUN, 1 = S_DROP)
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter int               cXLEN    = 32,
  parameter logic [cXLEN-1:0] cResetPc = 32'h0000_0000,
  parameter int               cDepth   = 2
) (
  input  logic             iClk,
  input  logic             iRst,
  output logic             oMemReq,
  output logic [cXLEN-1:0] oMemAddr,
  input  logic             iMemGnt,
  input  logic             iMemRvalid,
  input  logic [cXLEN-1:0] iMemRdata,
  output logic [cXLEN-1:0] oInst,
  output logic [cXLEN-1:0] oCurPc,
  output logic             oInstDv,
  input  logic             iStall,
  input  logic             iFlushPipe,
  input  logic [cXLEN-1:0] iFlushPc,
  output logic             oProtoErr,
  output logic             oDbgState
);

  localparam int cPtrW = (cDepth > 1) ? $clog2(cDepth) : 1;
  localparam int cCntW = $clog2(cDepth + 1);

  typedef logic [cPtrW-1:0] ptr_t;
  typedef logic [cCntW-1:0] cnt_t;
  typedef enum logic { S_RUN = 1'b0, S_DROP = 1'b1 } state_t;

  state_t           state_q,    state_d;
  logic [cXLEN-1:0] pc_q,       pc_d;
  cnt_t             out_cnt_q,  out_cnt_d;
  cnt_t             drop_cnt_q, drop_cnt_d;
  logic [cXLEN-1:0] fifo_inst_q [cDepth];
  logic [cXLEN-1:0] fifo_inst_d [cDepth];
  logic [cXLEN-1:0] fifo_pc_q   [cDepth];
  logic [cXLEN-1:0] fifo_pc_d   [cDepth];
  ptr_t             fifo_rd_q,  fifo_rd_d;
  ptr_t             fifo_wr_q,  fifo_wr_d;
  cnt_t             fifo_cnt_q, fifo_cnt_d;
  logic [cXLEN-1:0] tag_q       [cDepth];
  logic [cXLEN-1:0] tag_d       [cDepth];
  ptr_t             tag_rd_q,   tag_rd_d;
  ptr_t             tag_wr_q,   tag_wr_d;
  logic             err_q,      err_d;

  logic             mem_req;
  logic             gnt_fire;
  logic             rsp_ok;
  logic             fifo_pop;
  logic [cCntW:0]   slots_used;
  cnt_t             flush_left;
  logic             unused_flush_lo;

  // The low two bits of the redirect target are don't-care.
  assign unused_flush_lo = ^iFlushPc[1:0];

  function automatic ptr_t ptr_inc(input ptr_t p);
    if (p == ptr_t'(cDepth - 1)) return '0;
    return p + ptr_t'(1);
  endfunction

  always_comb begin
    fifo_pop = (fifo_cnt_q != '0) && !iStall;
    // A word popped this cycle frees its slot in time for a new request,
    // which is what sustains one instruction per cycle at latency 1.
    slots_used = (cCntW+1)'(out_cnt_q) + (cCntW+1)'(fifo_cnt_q)
               - (cCntW+1)'(fifo_pop);
    mem_req    = !iRst && (state_q == S_RUN) && !iFlushPipe
               && (slots_used < (cCntW+1)'(cDepth));
    gnt_fire   = mem_req && iMemGnt;
    rsp_ok     = iMemRvalid && (out_cnt_q != '0);
    flush_left = out_cnt_q - cnt_t'(rsp_ok);

    state_d     = state_q;
    pc_d        = pc_q;
    out_cnt_d   = out_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    fifo_inst_d = fifo_inst_q;
    fifo_pc_d   = fifo_pc_q;
    fifo_rd_d   = fifo_rd_q;
    fifo_wr_d   = fifo_wr_q;
    fifo_cnt_d  = fifo_cnt_q;
    tag_d       = tag_q;
    tag_rd_d    = tag_rd_q;
    tag_wr_d    = tag_wr_q;
    err_d       = err_q | (iMemRvalid && (out_cnt_q == '0));

    if (iFlushPipe) begin
      // Everything still owed by memory (minus a response landing now)
      // belongs to the old path and must be swallowed.
      pc_d       = {iFlushPc[cXLEN-1:2], 2'b00};
      fifo_rd_d  = '0;
      fifo_wr_d  = '0;
      fifo_cnt_d = '0;
      tag_rd_d   = '0;
      tag_wr_d   = '0;
      out_cnt_d  = flush_left;
      drop_cnt_d = flush_left;
      state_d    = (flush_left != '0) ? S_DROP : S_RUN;
    end else if (state_q == S_DROP) begin
      if (rsp_ok) begin
        out_cnt_d  = out_cnt_q - cnt_t'(1);
        drop_cnt_d = drop_cnt_q - cnt_t'(1);
        if (drop_cnt_q == cnt_t'(1)) state_d = S_RUN;
      end
    end else begin
      if (gnt_fire) begin
        tag_d[tag_wr_q] = pc_q;
        tag_wr_d        = ptr_inc(tag_wr_q);
        pc_d            = pc_q + cXLEN'(4);
      end
      if (rsp_ok) begin
        fifo_inst_d[fifo_wr_q] = iMemRdata;
        fifo_pc_d[fifo_wr_q]   = tag_q[tag_rd_q];
        fifo_wr_d              = ptr_inc(fifo_wr_q);
        tag_rd_d               = ptr_inc(tag_rd_q);
      end
      if (fifo_pop) fifo_rd_d = ptr_inc(fifo_rd_q);
      fifo_cnt_d = fifo_cnt_q + cnt_t'(rsp_ok) - cnt_t'(fifo_pop);
      out_cnt_d  = out_cnt_q + cnt_t'(gnt_fire) - cnt_t'(rsp_ok);
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q    <= S_RUN;
      pc_q       <= cResetPc;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      fifo_rd_q  <= '0;
      fifo_wr_q  <= '0;
      fifo_cnt_q <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < cDepth; i++) begin
        fifo_inst_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
        tag_q[i]       <= '0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_cnt_q   <= out_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      fifo_inst_q <= fifo_inst_d;
      fifo_pc_q   <= fifo_pc_d;
      fifo_rd_q   <= fifo_rd_d;
      fifo_wr_q   <= fifo_wr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      tag_q       <= tag_d;
      tag_rd_q    <= tag_rd_d;
      tag_wr_q    <= tag_wr_d;
      err_q       <= err_d;
    end
  end

  assign oMemReq   = mem_req;
  assign oMemAddr  = pc_q;
  assign oInstDv   = !iRst && (fifo_cnt_q != '0);
  assign oInst     = oInstDv ? fifo_inst_q[fifo_rd_q] : '0;
  assign oCurPc    = oInstDv ? fifo_pc_q[fifo_rd_q]   : '0;
  assign oProtoErr = err_q;
  assign oDbgState = state_q;

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
//   Directed bench for inst_fetch: a table of per-cycle vectors where the
//   bench plays memory by hand, then hand-written sequences driven through an
//   in-order memory model with programmable latency, and a long randomized
//   run checked against a reference PC model.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // ---------------- clock / reset / DUT ----------------
  logic        iClk = 1'b0;
  logic        iRst;
  logic        oMemReq;
  logic [31:0] oMemAddr;
  logic        iMemGnt;
  logic        iMemRvalid;
  logic [31:0] iMemRdata;
  logic [31:0] oInst;
  logic [31:0] oCurPc;
  logic        oInstDv;
  logic        iStall;
  logic        iFlushPipe;
  logic [31:0] iFlushPc;
  logic        oProtoErr;
  logic        oDbgState;

  always #5 iClk = ~iClk;

  inst_fetch #(
    .cXLEN   (32),
    .cResetPc(RESET_PC),
    .cDepth  (2)
  ) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .oMemReq   (oMemReq),
    .oMemAddr  (oMemAddr),
    .iMemGnt   (iMemGnt),
    .iMemRvalid(iMemRvalid),
    .iMemRdata (iMemRdata),
    .oInst     (oInst),
    .oCurPc    (oCurPc),
    .oInstDv   (oInstDv),
    .iStall    (iStall),
    .iFlushPipe(iFlushPipe),
    .iFlushPc  (iFlushPc),
    .oProtoErr (oProtoErr),
    .oDbgState (oDbgState)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int consumed = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t       pend_q[$];
  int          last_due = 0;
  logic [31:0] exp_q[$];

  logic        prev_req, prev_gnt, prev_flush;
  logic [31:0] prev_addr;
  logic        samp_req, samp_dv, samp_state, samp_err;
  logic [31:0] samp_addr, samp_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0] ^ 16'h0013};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge iClk);
      iRst = 1'b1; iMemGnt = 1'b0; iMemRvalid = 1'b0; iMemRdata = '0;
      iStall = 1'b0; iFlushPipe = 1'b0; iFlushPc = '0;
      #1;
      if (i == n - 1) begin
        check("rst_req",  {31'b0, oMemReq}, 32'd0);
        check("rst_dv",   {31'b0, oInstDv}, 32'd0);
        check("rst_inst", oInst,            32'd0);
        check("rst_pc",   oCurPc,           32'd0);
      end
      @(posedge iClk);
      cyc++;
    end
    pend_q.delete();
    last_due = 0;
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    prev_req = 1'b0; prev_gnt = 1'b0; prev_flush = 1'b0; prev_addr = '0;
    consumed = 0;
  endtask

  // One clock cycle: drive inputs (memory model supplies the response),
  // sample outputs, run the scoreboard, record any granted request.
  task automatic step(input logic gnt, input logic stall, input logic flush,
                      input logic [31:0] fpc, input int lat);
    int          due;
    logic [31:0] e;
    @(negedge iClk);
    iRst = 1'b0; iMemGnt = gnt; iStall = stall; iFlushPipe = flush; iFlushPc = fpc;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      iMemRvalid = 1'b1;
      iMemRdata  = mem_word(pend_q[0].addr);
      void'(pend_q.pop_front());
    end else begin
      iMemRvalid = 1'b0;
      iMemRdata  = $urandom;
    end
    #1;
    samp_req = oMemReq; samp_addr = oMemAddr; samp_dv = oInstDv;
    samp_pc = oCurPc; samp_state = oDbgState; samp_err = oProtoErr;

    if (prev_req && !prev_gnt && !prev_flush && !flush) begin
      check("req_hold",  {31'b0, oMemReq}, 32'd1);
      check("addr_hold", oMemAddr, prev_addr);
    end

    if (flush) begin
      exp_q.delete();
      exp_q.push_back({fpc[31:2], 2'b00});
    end else if (oInstDv && !stall) begin
      e = exp_q.pop_front();
      check("cur_pc", oCurPc, e);
      check("inst",   oInst,  mem_word(oCurPc));
      if (exp_q.size() == 0) exp_q.push_back(e + 32'd4);
      consumed++;
    end

    if (oMemReq && gnt) begin
      check("addr_align", {30'b0, oMemAddr[1:0]}, 32'd0);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      pend_q.push_back('{addr: oMemAddr, due: due});
      last_due = due;
    end

    prev_req = oMemReq; prev_gnt = gnt; prev_flush = flush; prev_addr = oMemAddr;
    @(posedge iClk);
    cyc++;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst, gnt, rv;
    logic [31:0] rdata;
    logic        stall, flush;
    logic [31:0] fpc;
    logic        req;
    logic [31:0] addr;
    logic        dv;
    logic [31:0] inst, pc;
    logic        err;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, gnt, rv, input logic [31:0] rdata,
                              input logic stall, flush, input logic [31:0] fpc,
                              input logic req, input logic [31:0] addr,
                              input logic dv, input logic [31:0] inst, pc,
                              input logic err);
    vec_t v;
    v.rst = rst; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.stall = stall;
    v.flush = flush; v.fpc = fpc; v.req = req; v.addr = addr; v.dv = dv;
    v.inst = inst; v.pc = pc; v.err = err;
    return v;
  endfunction

  initial begin
    iRst = 1'b1; iMemGnt = 1'b0; iMemRvalid = 1'b0; iMemRdata = '0;
    iStall = 1'b0; iFlushPipe = 1'b0; iFlushPc = '0;
    do_reset(2);

    //             rst gnt rv rdata                  stl fl fpc        req addr        dv inst                  pc      err
    vecs.push_back(mk(1, 0, 0, 32'h0,                0, 0, 32'h0,      0, 32'h0,   0, 32'h0,                32'h0,   0));
    vecs.push_back(mk(0, 1, 0, 32'h0,                0, 0, 32'h0,      1, 32'h0,   0, 32'h0,                32'h0,   0));
    vecs.push_back(mk(0, 1, 1, mem_word(32'h0),      0, 0, 32'h0,      1, 32'h4,   0, 32'h0,                32'h0,   0));
    vecs.push_back(mk(0, 1, 1, mem_word(32'h4),      0, 0, 32'h0,      1, 32'h8,   1, mem_word(32'h0),      32'h0,   0));
    vecs.push_back(mk(0, 0, 1, mem_word(32'h8),      1, 0, 32'h0,      0, 32'hC,   1, mem_word(32'h4),      32'h4,   0));
    vecs.push_back(mk(0, 1, 0, 32'h0,                1, 0, 32'h0,      0, 32'hC,   1, mem_word(32'h4),      32'h4,   0));
    vecs.push_back(mk(0, 1, 0, 32'h0,                0, 0, 32'h0,      1, 32'hC,   1, mem_word(32'h4),      32'h4,   0));
    vecs.push_back(mk(0, 0, 0, 32'h0,                0, 0, 32'h0,      1, 32'h10,  1, mem_word(32'h8),      32'h8,   0));
    vecs.push_back(mk(0, 0, 1, mem_word(32'hC),      0, 0, 32'h0,      1, 32'h10,  0, 32'h0,                32'h0,   0));
    vecs.push_back(mk(0, 1, 0, 32'h0,                0, 1, 32'h103,    0, 32'h10,  1, mem_word(32'hC),      32'hC,   0));
    vecs.push_back(mk(0, 0, 0, 32'h0,                0, 0, 32'h0,      1, 32'h100, 0, 32'h0,                32'h0,   0));
    vecs.push_back(mk(0, 1, 0, 32'h0,                0, 0, 32'h0,      1, 32'h100, 0, 32'h0,                32'h0,   0));
    vecs.push_back(mk(0, 0, 1, mem_word(32'h100),    0, 0, 32'h0,      1, 32'h104, 0, 32'h0,                32'h0,   0));
    vecs.push_back(mk(0, 0, 0, 32'h0,                1, 0, 32'h0,      1, 32'h104, 1, mem_word(32'h100),    32'h100, 0));
    vecs.push_back(mk(0, 0, 1, 32'hBAD0_BAD0,        0, 0, 32'h0,      1, 32'h104, 1, mem_word(32'h100),    32'h100, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,                0, 0, 32'h0,      1, 32'h104, 0, 32'h0,                32'h0,   1));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge iClk);
      iRst = vecs[i].rst; iMemGnt = vecs[i].gnt; iMemRvalid = vecs[i].rv;
      iMemRdata = vecs[i].rdata; iStall = vecs[i].stall;
      iFlushPipe = vecs[i].flush; iFlushPc = vecs[i].fpc;
      #1;
      check($sformatf("v%0d_req", i),  {31'b0, oMemReq},   {31'b0, vecs[i].req});
      check($sformatf("v%0d_addr", i), oMemAddr,           vecs[i].addr);
      check($sformatf("v%0d_dv", i),   {31'b0, oInstDv},   {31'b0, vecs[i].dv});
      check($sformatf("v%0d_inst", i), oInst,              vecs[i].inst);
      check($sformatf("v%0d_pc", i),   oCurPc,             vecs[i].pc);
      check($sformatf("v%0d_err", i),  {31'b0, oProtoErr}, {31'b0, vecs[i].err});
      @(posedge iClk);
      cyc++;
    end

    // ---- streaming from reset: one instruction per cycle ----
    do_reset(2);
    step(1, 0, 0, 0, 1);
    check("s1_first_req",  {31'b0, samp_req}, 32'd1);
    check("s1_first_addr", samp_addr, RESET_PC);
    check("s1_err_clear",  {31'b0, samp_err}, 32'd0);
    for (int i = 0; i < 11; i++) step(1, 0, 0, 0, 1);
    check("s1_throughput", consumed, 32'd10);

    // ---- flush with two reads outstanding at latency 3 ----
    do_reset(2);
    step(1, 0, 0, 0, 3);
    step(1, 0, 0, 0, 3);
    step(1, 0, 1, 32'h100, 3);
    step(1, 0, 0, 0, 1);
    check("s2_drop_state_a", {31'b0, samp_state}, 32'd1);
    check("s2_drop_noreq",   {31'b0, samp_req},   32'd0);
    check("s2_drop_nodv",    {31'b0, samp_dv},    32'd0);
    step(1, 0, 0, 0, 1);
    check("s2_drop_state_b", {31'b0, samp_state}, 32'd1);
    step(1, 0, 0, 0, 1);
    check("s2_run_state", {31'b0, samp_state}, 32'd0);
    check("s2_run_req",   {31'b0, samp_req},   32'd1);
    check("s2_run_addr",  samp_addr,           32'h100);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1);
    check("s2_count", consumed, 32'd4);

    // ---- flush coincident with a response and a pop, nothing left owed ----
    do_reset(2);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1);
    step(1, 0, 1, 32'h200, 1);
    check("s3a_flush_dv", {31'b0, samp_dv}, 32'd1);
    check("s3a_flush_pc", samp_pc, 32'h4);
    step(1, 0, 0, 0, 1);
    check("s3a_state", {31'b0, samp_state}, 32'd0);
    check("s3a_req",   {31'b0, samp_req},   32'd1);
    check("s3a_addr",  samp_addr,           32'h200);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1);
    check("s3a_count", consumed, 32'd4);

    // ---- flush coincident with a response, one read still owed ----
    do_reset(2);
    step(1, 0, 0, 0, 3);
    step(1, 0, 0, 0, 3);
    step(1, 0, 0, 0, 3);
    step(1, 0, 1, 32'h300, 1);
    step(1, 0, 0, 0, 1);
    check("s3b_drop_state", {31'b0, samp_state}, 32'd1);
    check("s3b_drop_noreq", {31'b0, samp_req},   32'd0);
    step(1, 0, 0, 0, 1);
    check("s3b_state", {31'b0, samp_state}, 32'd0);
    check("s3b_addr",  samp_addr,           32'h300);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1);
    check("s3b_count", consumed, 32'd3);

    // ---- decoder stall for five cycles while 0x8 is presented ----
    do_reset(2);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 0, 1);
      check("s4_hold_dv",  {31'b0, samp_dv},  32'd1);
      check("s4_hold_pc",  samp_pc,           32'h8);
      check("s4_req_low",  {31'b0, samp_req}, 32'd0);
    end
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 1);
    check("s4_count", consumed, 32'd8);

    // ---- grant held low at the top of the address space, then wrap ----
    do_reset(2);
    step(0, 0, 1, 32'hFFFF_FFFC, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1);
      check("s5_req",  {31'b0, samp_req}, 32'd1);
      check("s5_addr", samp_addr,         32'hFFFF_FFFC);
    end
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    check("s5_wrap_addr", samp_addr, 32'h0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1);
    check("s5_count", consumed, 32'd3);

    // ---- randomized traffic with a mid-run reset ----
    do_reset(2);
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) do_reset(1);
      step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 2, $urandom, $urandom_range(1, 4));
    end
    check("rand_err",      {31'b0, samp_err}, 32'd0);
    check("rand_progress", {31'b0, consumed >= 1000}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
